// File: rtl/reg_issue_pkg.sv
// reg_issue shared types
// Register widths and the issue request bundle
package reg_issue_pkg;

  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  typedef logic [AW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t srcA;
    reg_idx_t srcB;
    reg_idx_t dest;
    logic     writes;
  } issue_req_t;

endpackage

// File: rtl/reg_issue_scoreboard.sv
// reg_issue busy scoreboard
// One busy bit per register; clear applied before set
module reg_issue_scoreboard #(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic          set_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic [AW-1:0] lkA_i,
  input  logic [AW-1:0] lkB_i,
  input  logic [AW-1:0] lkD_i,
  output logic          bsyA_o,
  output logic          bsyB_o,
  output logic          bsyD_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Writeback clear first, then issue set, so a same-reg collision stays busy
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
  end

  // Busy vector register
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign bsyA_o = busy_q[lkA_i];
  assign bsyB_o = busy_q[lkB_i];
  assign bsyD_o = busy_q[lkD_i];

endmodule

// File: rtl/reg_issue.sv
// reg_issue: operand issue stage in front of reg_file
// Scoreboarded RAW/WAW stall, writeback bypass, output register
module reg_issue #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_srcA,
  input  logic [AW-1:0] in_srcB,
  input  logic [AW-1:0] in_dest,
  input  logic          in_writes,
  output logic [AW-1:0] raddrA,
  output logic [AW-1:0] raddrB,
  input  logic [DW-1:0] data_outA,
  input  logic [DW-1:0] data_outB,
  output logic          RegWrite,
  output logic [AW-1:0] write_register,
  output logic [DW-1:0] data_in,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_opA,
  output logic [DW-1:0] out_opB,
  output logic [AW-1:0] out_dest,
  output logic          out_writes
);

  import reg_issue_pkg::*;

  issue_req_t    req;
  logic          bypA, bypB, clrD;
  logic          bsyA, bsyB, bsyD;
  logic          hazA, hazB, hazD;
  logic          accept;
  logic [DW-1:0] opA, opB;

  logic          out_valid_q;
  logic [DW-1:0] out_opA_q, out_opB_q;
  logic [AW-1:0] out_dest_q;
  logic          out_writes_q;

  assign req = '{srcA: in_srcA, srcB: in_srcB,
                 dest: in_dest, writes: in_writes};

  assign raddrA = req.srcA;
  assign raddrB = req.srcB;

  assign RegWrite       = wb_valid;
  assign write_register = wb_reg;
  assign data_in        = wb_data;

  assign bypA = wb_valid && (wb_reg == req.srcA);
  assign bypB = wb_valid && (wb_reg == req.srcB);
  assign clrD = wb_valid && (wb_reg == req.dest);

  assign opA = bypA ? wb_data : data_outA;
  assign opB = bypB ? wb_data : data_outB;

  reg_issue_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (wb_valid),
    .clr_idx_i (wb_reg),
    .set_i     (accept && req.writes),
    .set_idx_i (req.dest),
    .lkA_i     (req.srcA),
    .lkB_i     (req.srcB),
    .lkD_i     (req.dest),
    .bsyA_o    (bsyA),
    .bsyB_o    (bsyB),
    .bsyD_o    (bsyD)
  );

  assign hazA = bsyA && !bypA;
  assign hazB = bsyB && !bypB;
  assign hazD = req.writes && bsyD && !clrD;

  assign in_ready = (!out_valid_q || out_ready)
                  && !hazA && !hazB && !hazD;
  assign accept   = in_valid && in_ready;

  // Output register: load on accept, drop valid on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_opA_q    <= '0;
      out_opB_q    <= '0;
      out_dest_q   <= '0;
      out_writes_q <= 1'b0;
    end else if (accept) begin
      out_valid_q  <= 1'b1;
      out_opA_q    <= opA;
      out_opB_q    <= opB;
      out_dest_q   <= req.dest;
      out_writes_q <= req.writes;
    end else if (out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_opA    = out_opA_q;
  assign out_opB    = out_opB_q;
  assign out_dest   = out_dest_q;
  assign out_writes = out_writes_q;

endmodule

// File: doc/reg_issue.md
# reg_issue

Operand-issue stage sitting directly in front of `reg_file`. It accepts pre-decoded register-operand requests with a valid/ready handshake, drives `reg_file` read addresses, and latches operands into an output register for the execute stage. It routes writebacks into `reg_file`'s write port and forwards same-cycle writeback data. A per-register busy scoreboard stalls any request whose source or destination has a write still in flight.

## Interface
Parameters:
- `NREGS`, 16: number of architectural registers.
- `AW`, 4: register address width; `2**AW == NREGS`.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream request valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_srcA`, `in_srcB`  in  AW  source register indices.
- `in_dest`  in  AW  destination register index.
- `in_writes`  in  1  request will produce a writeback to `in_dest`.
- `raddrA`, `raddrB`  out  AW  to `reg_file` read ports.
- `data_outA`, `data_outB`  in  DW  from `reg_file` read ports; combinational read.
- `RegWrite`  out  1  to `reg_file` write enable.
- `write_register`  out  AW  to `reg_file` write address.
- `data_in`  out  DW  to `reg_file` write data.
- `wb_valid`  in  1  writeback from execute/memory is valid.
- `wb_reg`  in  AW  writeback destination.
- `wb_data`  in  DW  writeback value.
- `out_valid`  out  1  issued operands valid.
- `out_ready`  in  1  execute stage accepts.
- `out_opA`, `out_opB`  out  DW  latched operands.
- `out_dest`  out  AW  latched destination.
- `out_writes`  out  1  latched write flag.

## Operation
- `raddrA = in_srcA` and `raddrB = in_srcB`, both combinational.
- Writeback pass-through is combinational: `RegWrite = wb_valid`, `write_register = wb_reg`, `data_in = wb_data`.
- A writeback is always performed, even to a non-busy register.
- Bypass: `bypA = wb_valid && wb_reg == in_srcA`, and likewise `bypB`. The captured operand is `wb_data` if bypassed, otherwise `data_outA`/`data_outB`.
- The scoreboard is a `busy[NREGS]` vector.
  - `clrhit(r) = wb_valid && wb_reg == r`.
  - `hazA = busy[in_srcA] && !clrhit(in_srcA)`; `hazB` likewise.
  - `hazD = in_writes && busy[in_dest] && !clrhit(in_dest)` (WAW).
- `in_ready = (!out_valid || out_ready) && !hazA && !hazB && !hazD`.
- `in_ready` is computed from `in_*` regardless of `in_valid`.
- Accept when `in_valid && in_ready`. On accept:
  - load the output register with operands, `in_dest`, and `in_writes`;
  - set `out_valid = 1`;
  - if `in_writes`, set `busy[in_dest]`.
- If `out_valid && out_ready` with no accept, clear `out_valid`; other output fields hold.
- Busy update order within a cycle: apply the clear from `wb_valid` first, then the set from accept. Same register in the same cycle therefore ends busy.
- No state machine beyond `out_valid`: IDLE (`out_valid = 0`) and FULL (`out_valid = 1`).
  - IDLE → FULL on accept.
  - FULL → IDLE on drain without accept.
  - FULL → FULL on drain plus accept, or on hold.

## Timing
- Reset values: `busy = 0`, `out_valid = 0`, `out_opA = out_opB = 0`, `out_dest = 0`, `out_writes = 0`.
- Reset mid-operation discards the held request and all busy bits. Writebacks presented during reset still drive `RegWrite` (pass-through).
- Latency: request accepted at edge N; `out_*` valid after edge N; busy visible to the next request after edge N.
- Throughput: 1 request/cycle when there are no hazards and `out_ready = 1`.
- A hazard resolved by `wb_valid` in cycle N allows acceptance in cycle N, with the operand taken from the bypass.
- `out_*` are stable while `out_valid && !out_ready`.
- Upstream holds `in_*` stable while `in_valid && !in_ready`.

## Structure
- The shared package holds `AW`, `DW`, `NREGS`, and a `reg_idx_t` typedef (`logic [AW-1:0]`).
- The package also holds an `issue_req_t` struct: srcA, srcB, dest, writes.
- One natural sub-module: `scoreboard`, containing the busy vector with set/clear ports and 3 combinational lookup ports.

## Test plan
- After reset with `reg_file` r3=10, r5=20: request srcA=3, srcB=5, dest=7, writes=1 → next cycle `out_valid=1`, `out_opA=10`, `out_opB=20`, `out_dest=7`; `busy[7]=1`.
- RAW stall: with r7 busy, request srcA=7 → `in_ready=0` for 3 cycles. Then `wb_valid=1`, `wb_reg=7`, `wb_data=8'hA5` in the same cycle → accepted, `out_opA=8'hA5`, `RegWrite=1` to r7, `busy[7]` cleared.
- WAW: with r4 busy, request writes=1, dest=4 → `in_ready=0` until writeback to r4; simultaneous writeback plus accept leaves `busy[4]=1`.
- Backpressure: `out_ready=0` with `out_valid=1` → `in_ready=0`; `out_*` unchanged for 5 cycles. Raise `out_ready` → new request accepted the same cycle.
- Back-to-back: 4 independent requests with `out_ready=1` → 4 consecutive `out_valid` cycles with the correct operands.
- Reset with `out_valid=1` and busy={2,9} → next cycle `out_valid=0`, all busy=0; a request with srcA=2 is accepted immediately.
